ray_dda_stepper: RTL and testbench

Per-ray grid traversal engine of the raycaster; sits directly upstream of the VGA column renderer inside `vga_top`. It accepts one ray's starting map cell, step directions and fixed-point side/delta distances, walks the tile map with the DDA algorithm through a synchronous map-ROM read port, and returns the perpendicular wall distance, hit side and tile code. The column renderer consumes these results to size each wall slice.

---
 rtl/raycaster_pkg.sv | 28 ++
 rtl/ray_dda_stepper_sat_add.sv | 18 +
 rtl/ray_dda_stepper.sv | 204 ++++++++++++++++++++
 tb/tb_ray_dda_stepper.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/raycaster_pkg.sv
// Shared raycaster definitions: tile codes, DDA state encoding and default
// fixed-point widths used by the stepper and the column renderer.
package raycaster_pkg;

  localparam int DW_DEF   = 16;
  localparam int FRAC_DEF = 8;

  localparam logic [3:0] TILE_EMPTY = 4'h0;
  localparam logic [3:0] TILE_OOB   = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_STEP  = 3'd1,
    S_FETCH = 3'd2,
    S_CHECK = 3'd3,
    S_DONE  = 3'd4
  } dda_state_e;

  // Distance back off by one delta, floored at zero (a saturated side distance
  // can otherwise land below the true pre-step value but never wraps).
  function automatic logic [DW_DEF-1:0] sub_floor(input logic [DW_DEF-1:0] a,
                                                  input logic [DW_DEF-1:0] b);
    logic [DW_DEF:0] d;
    d = {1'b0, a} - {1'b0, b};
    return d[DW_DEF] ? '0 : d[DW_DEF-1:0];
  endfunction

endpackage

// File: rtl/ray_dda_stepper_sat_add.sv
// Unsigned saturating adder: clamps to all ones on carry out.
module sat_add #(
  parameter int W = 16
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] sum_o
);

  logic [W:0] full;

  // Widen by one bit so the carry tells us when to clamp.
  always_comb begin
    full  = {1'b0, a_i} + {1'b0, b_i};
    sum_o = full[W] ? '1 : full[W-1:0];
  end

endmodule

// File: rtl/ray_dda_stepper.sv
// Per-ray DDA grid walker. Steps one cell per STEP, reads the tile through a
// one-cycle-latency map ROM (FETCH/CHECK) and reports the first solid tile,
// leaving the map, or running out of step budget.
module ray_dda_stepper
  import raycaster_pkg::*;
#(
  parameter int MAP_W     = 16,
  parameter int MAP_H     = 16,
  parameter int DW        = DW_DEF,
  parameter int FRAC      = FRAC_DEF,
  parameter int MAX_STEPS = 32,
  localparam int XW = $clog2(MAP_W),
  localparam int YW = $clog2(MAP_H),
  localparam int AW = XW + YW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start_valid,
  output logic          start_ready,
  input  logic [XW-1:0] start_map_x,
  input  logic [YW-1:0] start_map_y,
  input  logic          step_x_neg,
  input  logic          step_y_neg,
  input  logic [DW-1:0] side_dist_x,
  input  logic [DW-1:0] side_dist_y,
  input  logic [DW-1:0] delta_dist_x,
  input  logic [DW-1:0] delta_dist_y,
  output logic [AW-1:0] map_addr,
  input  logic [3:0]    map_data,
  output logic          hit_valid,
  input  logic          hit_ready,
  output logic [DW-1:0] perp_dist,
  output logic          hit_side,
  output logic [3:0]    hit_tile,
  output logic          hit_timeout
);

  localparam int CW = $clog2(MAX_STEPS + 1);

  if (FRAC >= DW) begin : g_cfg_err
    $error("FRAC must leave at least one integer bit in DW");
  end

  dda_state_e    state_q, state_d;
  logic [XW-1:0] mx_q, mx_d;
  logic [YW-1:0] my_q, my_d;
  logic          sxn_q, sxn_d, syn_q, syn_d;
  logic [DW-1:0] sdx_q, sdx_d, sdy_q, sdy_d;
  logic [DW-1:0] ddx_q, ddx_d, ddy_q, ddy_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          side_q, side_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] perp_q, perp_d;
  logic          hside_q, hside_d;
  logic [3:0]    tile_q, tile_d;
  logic          tout_q, tout_d;

  logic [DW-1:0] sdx_sum, sdy_sum;
  logic [XW-1:0] mx_nxt;
  logic [YW-1:0] my_nxt;
  logic          take_x, x_edge, y_edge;

  sat_add #(.W(DW)) u_add_x (.a_i(sdx_q), .b_i(ddx_q), .sum_o(sdx_sum));
  sat_add #(.W(DW)) u_add_y (.a_i(sdy_q), .b_i(ddy_q), .sum_o(sdy_sum));

  assign start_ready = (state_q == S_IDLE);
  assign hit_valid   = (state_q == S_DONE);
  assign map_addr    = addr_q;
  assign perp_dist   = perp_q;
  assign hit_side    = hside_q;
  assign hit_tile    = tile_q;
  assign hit_timeout = tout_q;

  // Next-state and datapath decode; every register holds unless a state acts.
  always_comb begin
    state_d = state_q;
    mx_d    = mx_q;
    my_d    = my_q;
    sxn_d   = sxn_q;
    syn_d   = syn_q;
    sdx_d   = sdx_q;
    sdy_d   = sdy_q;
    ddx_d   = ddx_q;
    ddy_d   = ddy_q;
    cnt_d   = cnt_q;
    side_d  = side_q;
    addr_d  = addr_q;
    perp_d  = perp_q;
    hside_d = hside_q;
    tile_d  = tile_q;
    tout_d  = tout_q;

    // Ties go to X so equal side distances are resolved deterministically.
    take_x = (sdx_q <= sdy_q);
    x_edge = sxn_q ? (mx_q == '0) : (mx_q == XW'(MAP_W - 1));
    y_edge = syn_q ? (my_q == '0) : (my_q == YW'(MAP_H - 1));
    mx_nxt = sxn_q ? (mx_q - XW'(1)) : (mx_q + XW'(1));
    my_nxt = syn_q ? (my_q - YW'(1)) : (my_q + YW'(1));

    unique case (state_q)
      S_IDLE: begin
        if (start_valid) begin
          mx_d    = start_map_x;
          my_d    = start_map_y;
          sxn_d   = step_x_neg;
          syn_d   = step_y_neg;
          sdx_d   = side_dist_x;
          sdy_d   = side_dist_y;
          ddx_d   = delta_dist_x;
          ddy_d   = delta_dist_y;
          cnt_d   = '0;
          state_d = S_STEP;
        end
      end
      S_STEP: begin
        side_d = ~take_x;
        if ((take_x && x_edge) || (!take_x && y_edge)) begin
          // Walking off the map: no ROM read, report an OOB pseudo-hit.
          perp_d  = '1;
          hside_d = ~take_x;
          tile_d  = TILE_OOB;
          tout_d  = 1'b0;
          state_d = S_DONE;
        end else begin
          if (take_x) begin
            mx_d   = mx_nxt;
            sdx_d  = sdx_sum;
            addr_d = {my_q, mx_nxt};
          end else begin
            my_d   = my_nxt;
            sdy_d  = sdy_sum;
            addr_d = {my_nxt, mx_q};
          end
          cnt_d   = cnt_q + CW'(1);
          state_d = S_FETCH;
        end
      end
      S_FETCH: state_d = S_CHECK;
      S_CHECK: begin
        if (map_data != TILE_EMPTY) begin
          perp_d  = side_q ? sub_floor(sdy_q, ddy_q) : sub_floor(sdx_q, ddx_q);
          hside_d = side_q;
          tile_d  = map_data;
          tout_d  = 1'b0;
          state_d = S_DONE;
        end else if (cnt_q == CW'(MAX_STEPS)) begin
          perp_d  = '1;
          hside_d = side_q;
          tile_d  = TILE_EMPTY;
          tout_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          state_d = S_STEP;
        end
      end
      S_DONE: if (hit_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM state register; reset aborts any ray in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Ray context and result registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mx_q    <= '0;
      my_q    <= '0;
      sxn_q   <= 1'b0;
      syn_q   <= 1'b0;
      sdx_q   <= '0;
      sdy_q   <= '0;
      ddx_q   <= '0;
      ddy_q   <= '0;
      cnt_q   <= '0;
      side_q  <= 1'b0;
      addr_q  <= '0;
      perp_q  <= '0;
      hside_q <= 1'b0;
      tile_q  <= '0;
      tout_q  <= 1'b0;
    end else begin
      mx_q    <= mx_d;
      my_q    <= my_d;
      sxn_q   <= sxn_d;
      syn_q   <= syn_d;
      sdx_q   <= sdx_d;
      sdy_q   <= sdy_d;
      ddx_q   <= ddx_d;
      ddy_q   <= ddy_d;
      cnt_q   <= cnt_d;
      side_q  <= side_d;
      addr_q  <= addr_d;
      perp_q  <= perp_d;
      hside_q <= hside_d;
      tile_q  <= tile_d;
      tout_q  <= tout_d;
    end
  end

endmodule

// File: tb/tb_ray_dda_stepper.sv
// Directed bench for ray_dda_stepper with a behavioural synchronous map ROM.
module tb_ray_dda_stepper;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_valid, start_ready;
  logic [3:0]  start_map_x, start_map_y;
  logic        step_x_neg, step_y_neg;
  logic [15:0] side_dist_x, side_dist_y, delta_dist_x, delta_dist_y;
  logic [7:0]  map_addr;
  logic [3:0]  map_data;
  logic        hit_valid, hit_ready;
  logic [15:0] perp_dist;
  logic        hit_side;
  logic [3:0]  hit_tile;
  logic        hit_timeout;

  logic [3:0]  rom [256];
  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  always @(posedge clk) map_data <= rom[map_addr];

  ray_dda_stepper #(.MAP_W(16), .MAP_H(16), .DW(16), .FRAC(8), .MAX_STEPS(4)) dut (
    .clk(clk), .reset(reset),
    .start_valid(start_valid), .start_ready(start_ready),
    .start_map_x(start_map_x), .start_map_y(start_map_y),
    .step_x_neg(step_x_neg), .step_y_neg(step_y_neg),
    .side_dist_x(side_dist_x), .side_dist_y(side_dist_y),
    .delta_dist_x(delta_dist_x), .delta_dist_y(delta_dist_y),
    .map_addr(map_addr), .map_data(map_data),
    .hit_valid(hit_valid), .hit_ready(hit_ready),
    .perp_dist(perp_dist), .hit_side(hit_side),
    .hit_tile(hit_tile), .hit_timeout(hit_timeout)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_map();
    for (int i = 0; i < 256; i++) rom[i] = 4'h0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch a ray, then count cycles until hit_valid (bounded).
  task automatic run_ray(input string tag, input logic [3:0] x, input logic [3:0] y,
                         input logic nx, input logic ny,
                         input logic [15:0] sdx, input logic [15:0] sdy,
                         input logic [15:0] ddx, input logic [15:0] ddy,
                         input int exp_lat);
    int n;
    start_map_x  = x;   start_map_y  = y;
    step_x_neg   = nx;  step_y_neg   = ny;
    side_dist_x  = sdx; side_dist_y  = sdy;
    delta_dist_x = ddx; delta_dist_y = ddy;
    start_valid  = 1'b1;
    tick();
    start_valid = 1'b0;
    n = 0;
    while (!hit_valid && n < 100) begin
      tick();
      n++;
    end
    chk({tag, "_lat"}, n, exp_lat);
  endtask

  task automatic check_res(input string tag, input logic [15:0] perp, input logic side,
                           input logic [3:0] tile, input logic tout, input logic [7:0] addr);
    chk({tag, "_valid"}, hit_valid, 1'b1);
    chk({tag, "_perp"},  perp_dist, perp);
    chk({tag, "_side"},  hit_side, side);
    chk({tag, "_tile"},  hit_tile, tile);
    chk({tag, "_tout"},  hit_timeout, tout);
    chk({tag, "_addr"},  map_addr, addr);
    chk({tag, "_rdy"},   start_ready, 1'b0);
  endtask

  task automatic accept(input string tag);
    hit_ready = 1'b1;
    tick();
    hit_ready = 1'b0;
    chk({tag, "_acc_rdy"}, start_ready, 1'b1);
    chk({tag, "_acc_vld"}, hit_valid, 1'b0);
  endtask

  initial begin
    reset = 1'b0;
    start_valid = 1'b0; hit_ready = 1'b0;
    start_map_x = '0; start_map_y = '0; step_x_neg = 1'b0; step_y_neg = 1'b0;
    side_dist_x = '0; side_dist_y = '0; delta_dist_x = '0; delta_dist_y = '0;
    clear_map();
    tick(); tick();
    chk("rst_ready", start_ready, 1'b1);
    chk("rst_valid", hit_valid, 1'b0);
    chk("rst_perp",  perp_dist, 16'h0);
    chk("rst_side",  hit_side, 1'b0);
    chk("rst_tile",  hit_tile, 4'h0);
    chk("rst_tout",  hit_timeout, 1'b0);
    chk("rst_addr",  map_addr, 8'h00);
    reset = 1'b1;
    tick();

    // Single X step into a wall at (3,2).
    clear_map(); rom[8'h23] = 4'h3;
    run_ray("basic", 4'd2, 4'd2, 1'b0, 1'b0, 16'h0080, 16'h0200, 16'h0100, 16'h0100, 3);
    check_res("basic", 16'h0080, 1'b0, 4'h3, 1'b0, 8'h23);
    accept("basic");

    // Equal side distances resolve to X.
    clear_map(); rom[8'h23] = 4'h5; rom[8'h32] = 4'h6;
    run_ray("tie", 4'd2, 4'd2, 1'b0, 1'b0, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 3);
    check_res("tie", 16'h0100, 1'b0, 4'h5, 1'b0, 8'h23);
    accept("tie");

    // Two steps: X to (3,2) empty, then Y (negative) to (3,1) wall.
    clear_map(); rom[8'h13] = 4'h9;
    run_ray("ystep", 4'd2, 4'd2, 1'b0, 1'b1, 16'h0080, 16'h00C0, 16'h0100, 16'h0100, 6);
    check_res("ystep", 16'h00C0, 1'b1, 4'h9, 1'b0, 8'h13);
    accept("ystep");

    // Saturated side distance: FF80+0100 clamps to FFFF, minus 0100.
    clear_map(); rom[8'h23] = 4'h2;
    run_ray("sat", 4'd2, 4'd2, 1'b0, 1'b0, 16'hFF80, 16'hFFFF, 16'h0100, 16'h0100, 3);
    check_res("sat", 16'hFEFF, 1'b0, 4'h2, 1'b0, 8'h23);
    accept("sat");

    // Leaving the map on X from column 15; address stays at last fetch.
    clear_map();
    run_ray("oobx", 4'd15, 4'd5, 1'b0, 1'b0, 16'h0080, 16'h0200, 16'h0100, 16'h0100, 1);
    check_res("oobx", 16'hFFFF, 1'b0, 4'hF, 1'b0, 8'h23);
    accept("oobx");

    // Leaving the map on Y from row 0 stepping negative.
    run_ray("ooby", 4'd7, 4'd0, 1'b0, 1'b1, 16'h0500, 16'h0010, 16'h0100, 16'h0100, 1);
    check_res("ooby", 16'hFFFF, 1'b1, 4'hF, 1'b0, 8'h23);
    accept("ooby");

    // Step budget of 4 exhausted in an empty map: (5,5) -> (9,5).
    run_ray("tmo", 4'd5, 4'd5, 1'b0, 1'b0, 16'h0080, 16'h1000, 16'h0100, 16'h0100, 12);
    check_res("tmo", 16'hFFFF, 1'b0, 4'h0, 1'b1, 8'h59);

    // Back-pressure: result held, new requests ignored.
    start_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("hold_valid", hit_valid, 1'b1);
      chk("hold_rdy",   start_ready, 1'b0);
      chk("hold_perp",  perp_dist, 16'hFFFF);
      chk("hold_tout",  hit_timeout, 1'b1);
    end
    start_valid = 1'b0;
    accept("hold");

    // Reset during FETCH aborts the ray.
    clear_map(); rom[8'h23] = 4'h3;
    start_map_x = 4'd2; start_map_y = 4'd2; step_x_neg = 1'b0; step_y_neg = 1'b0;
    side_dist_x = 16'h0080; side_dist_y = 16'h0200;
    delta_dist_x = 16'h0100; delta_dist_y = 16'h0100;
    start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
    tick();
    chk("mid_addr", map_addr, 8'h23);
    reset = 1'b0;
    #1;
    chk("mid_rdy",   start_ready, 1'b1);
    chk("mid_valid", hit_valid, 1'b0);
    chk("mid_addr0", map_addr, 8'h00);
    chk("mid_perp",  perp_dist, 16'h0);
    chk("mid_tile",  hit_tile, 4'h0);
    chk("mid_tout",  hit_timeout, 1'b0);
    tick();
    reset = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    chk("post_valid", hit_valid, 1'b0);
    chk("post_rdy",   start_ready, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
